// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-port round-robin arbiter in front of a single register
// file bus. Port 0 (I2C side) writes are gated by a goodCRC qualifier; port 1
// (protocol engine) writes are always issued. One transaction in flight.
//
// Handshake: a port holds reqN high while it wants service; requests are only
// sampled in IDLE. Once granted, the transaction runs to completion regardless
// of reqN, and ackN pulses for exactly one cycle in DONE. On the register bus,
// reg_req is a single-cycle strobe with reg_rnw/reg_addr/reg_wdata stable from
// ISSUE through DONE; read data is sampled RD_LAT cycles after the strobe.
module reg_bus_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    // port 0 (I2C side)
    input  logic              req0,
    input  logic              rnw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              crc_ok0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    // port 1 (protocol engine)
    input  logic              req1,
    input  logic              rnw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    // shared register-file bus
    output logic              reg_req,
    output logic              reg_rnw,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    // status / debug
    output logic              busy,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    state_t             state;
    logic               last_grant;   // port granted most recently
    logic               cur_port;     // port owning the in-flight transaction
    logic               rejected;     // port 0 write dropped for bad CRC
    logic [1:0]         wait_cnt;     // remaining WAIT cycles minus one

    logic               grant_valid;
    logic               grant_port;
    logic               sel_rnw;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_reject;

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else if (req1) begin
            grant_port = 1'b1;
        end
        sel_rnw    = grant_port ? rnw1   : rnw0;
        sel_addr   = grant_port ? addr1  : addr0;
        sel_wdata  = grant_port ? wdata1 : wdata0;
        // CRC only qualifies port 0 writes
        sel_reject = ~grant_port & ~rnw0 & ~crc_ok0;
    end

    // Transaction FSM with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            rejected   <= 1'b0;
            wait_cnt   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            reg_req    <= 1'b0;
            reg_rnw    <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            reg_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_port;
                        cur_port   <= grant_port;
                        rejected   <= sel_reject;
                        reg_rnw    <= sel_rnw;
                        reg_addr   <= sel_addr;
                        reg_wdata  <= sel_wdata;
                        reg_req    <= ~sel_reject;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rejected || !reg_rnw) begin
                        // writes (issued or suppressed) complete next cycle
                        ack0  <= ~cur_port;
                        ack1  <= cur_port;
                        err0  <= rejected;
                        state <= DONE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        // last latency cycle: reg_rdata is valid now
                        ack0  <= ~cur_port;
                        ack1  <= cur_port;
                        if (cur_port) begin
                            rdata1 <= reg_rdata;
                        end else begin
                            rdata0 <= reg_rdata;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: one RD_LAT=1 instance for the main
// scenarios and one RD_LAT=3 instance for long-latency and reset-in-WAIT.
module tb_reg_bus_arbiter;

    logic        clk;
    logic        reset;

    // instance A (RD_LAT = 1)
    logic        req0, rnw0, crc_ok0, req1, rnw1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, err0, ack1, reg_req, reg_rnw, busy;
    logic [15:0] rdata0, rdata1, reg_wdata, reg_rdata;
    logic [7:0]  reg_addr;
    logic [1:0]  fsm_state;

    // instance B (RD_LAT = 3)
    logic        req0_b, rnw0_b;
    logic [7:0]  addr0_b;
    logic        ack0_b, err0_b, ack1_b, reg_req_b, reg_rnw_b, busy_b;
    logic [15:0] rdata0_b, rdata1_b, reg_wdata_b, reg_rdata_b;
    logic [7:0]  reg_addr_b;
    logic [1:0]  fsm_state_b;

    int n_vec;
    int n_miss;

    reg_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdata0(wdata0), .crc_ok0(crc_ok0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .reg_req(reg_req), .reg_rnw(reg_rnw), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .busy(busy), .fsm_state(fsm_state)
    );

    reg_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .rnw0(rnw0_b), .addr0(addr0_b), .wdata0(16'h0000), .crc_ok0(1'b1),
        .ack0(ack0_b), .rdata0(rdata0_b), .err0(err0_b),
        .req1(1'b0), .rnw1(1'b0), .addr1(8'h00), .wdata1(16'h0000),
        .ack1(ack1_b), .rdata1(rdata1_b),
        .reg_req(reg_req_b), .reg_rnw(reg_rnw_b), .reg_addr(reg_addr_b),
        .reg_wdata(reg_wdata_b), .reg_rdata(reg_rdata_b),
        .busy(busy_b), .fsm_state(fsm_state_b)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file model for instance A: data valid only in cycle T+1
    logic [15:0] mem [256];
    logic [3:0]  rd_cnt;
    always @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 4'd0;
        end else begin
            if (reg_req && reg_rnw) rd_cnt <= 4'd1;
            else if (rd_cnt != 4'd0 && rd_cnt != 4'd15) rd_cnt <= rd_cnt + 4'd1;
            if (reg_req && !reg_rnw) mem[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata = (rd_cnt == 4'd1) ? mem[reg_addr] : 16'hDEAD;

    // register file model for instance B: data valid only in cycle T+3
    logic [3:0] rd_cnt_b;
    always @(posedge clk) begin
        if (reset) begin
            rd_cnt_b <= 4'd0;
        end else if (reg_req_b && reg_rnw_b) begin
            rd_cnt_b <= 4'd1;
        end else if (rd_cnt_b != 4'd0 && rd_cnt_b != 4'd15) begin
            rd_cnt_b <= rd_cnt_b + 4'd1;
        end
    end
    assign reg_rdata_b = (rd_cnt_b == 4'd3) ? 16'h1234 : 16'hDEAD;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; rnw0 = 1'b0; crc_ok0 = 1'b1;
        step(); step(); step();
        n_vec++; if (reg_req !== 1'b0) begin n_miss++; $display("FAIL rst_reg_req: got %b want 0", reg_req); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if ({ack0, ack1, err0} !== 3'b000) begin n_miss++; $display("FAIL rst_acks: got %b want 000", {ack0, ack1, err0}); end
        n_vec++; if (reg_addr !== 8'h00) begin n_miss++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
        n_vec++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin n_miss++; $display("FAIL rst_rdata: got %h/%h want 0000/0000", rdata0, rdata1); end
        n_vec++; if (fsm_state !== 2'd0) begin n_miss++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
        req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
        step();
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_p1_write();
        req1 = 1'b1; rnw1 = 1'b0; addr1 = 8'h10; wdata1 = 16'hBEEF;
        step();
        req1 = 1'b0;
        n_vec++; if ({reg_req, reg_rnw} !== 2'b10) begin n_miss++; $display("FAIL p1w_req: got %b want 10", {reg_req, reg_rnw}); end
        n_vec++; if (reg_addr !== 8'h10 || reg_wdata !== 16'hBEEF) begin n_miss++; $display("FAIL p1w_bus: got %h/%h want 10/beef", reg_addr, reg_wdata); end
        n_vec++; if (ack1 !== 1'b0 || busy !== 1'b1) begin n_miss++; $display("FAIL p1w_issue: got ack1=%b busy=%b want 0/1", ack1, busy); end
        step();
        n_vec++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin n_miss++; $display("FAIL p1w_ack: got ack1=%b ack0=%b want 1/0", ack1, ack0); end
        n_vec++; if (rdata1 !== 16'h0000) begin n_miss++; $display("FAIL p1w_rdata: got %h want 0000", rdata1); end
        n_vec++; if (reg_req !== 1'b0 || reg_addr !== 8'h10) begin n_miss++; $display("FAIL p1w_hold: got req=%b addr=%h want 0/10", reg_req, reg_addr); end
        step();
        n_vec++; if (ack1 !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL p1w_end: got ack1=%b busy=%b want 0/0", ack1, busy); end
    endtask

    task automatic test_p0_read();
        req0 = 1'b1; rnw0 = 1'b1; addr0 = 8'h10; crc_ok0 = 1'b0;
        step();
        req0 = 1'b0;
        n_vec++; if ({reg_req, reg_rnw} !== 2'b11) begin n_miss++; $display("FAIL p0r_req: got %b want 11", {reg_req, reg_rnw}); end
        step();
        n_vec++; if (ack0 !== 1'b0 || busy !== 1'b1) begin n_miss++; $display("FAIL p0r_wait: got ack0=%b busy=%b want 0/1", ack0, busy); end
        step();
        n_vec++; if (ack0 !== 1'b1 || err0 !== 1'b0) begin n_miss++; $display("FAIL p0r_ack: got ack0=%b err0=%b want 1/0", ack0, err0); end
        n_vec++; if (rdata0 !== 16'hBEEF) begin n_miss++; $display("FAIL p0r_rdata: got %h want beef", rdata0); end
        step();
        n_vec++; if (ack0 !== 1'b0 || rdata0 !== 16'hBEEF) begin n_miss++; $display("FAIL p0r_hold: got ack0=%b rdata0=%h want 0/beef", ack0, rdata0); end
    endtask

    task automatic test_p0_write_ok();
        req0 = 1'b1; rnw0 = 1'b0; addr0 = 8'h20; wdata0 = 16'h1234; crc_ok0 = 1'b1;
        step();
        req0 = 1'b0;
        n_vec++; if (reg_req !== 1'b1 || reg_wdata !== 16'h1234) begin n_miss++; $display("FAIL p0w_req: got req=%b wdata=%h want 1/1234", reg_req, reg_wdata); end
        step();
        n_vec++; if (ack0 !== 1'b1 || err0 !== 1'b0) begin n_miss++; $display("FAIL p0w_ack: got ack0=%b err0=%b want 1/0", ack0, err0); end
        n_vec++; if (rdata0 !== 16'hBEEF) begin n_miss++; $display("FAIL p0w_rdata: got %h want beef", rdata0); end
        step();
    endtask

    task automatic test_crc_reject();
        req0 = 1'b1; rnw0 = 1'b0; addr0 = 8'h10; wdata0 = 16'h5555; crc_ok0 = 1'b0;
        step();
        req0 = 1'b0;
        n_vec++; if (reg_req !== 1'b0 || busy !== 1'b1) begin n_miss++; $display("FAIL crc_noreq: got req=%b busy=%b want 0/1", reg_req, busy); end
        step();
        n_vec++; if ({ack0, err0} !== 2'b11) begin n_miss++; $display("FAIL crc_ack_err: got %b want 11", {ack0, err0}); end
        step();
        n_vec++; if ({ack0, err0} !== 2'b00) begin n_miss++; $display("FAIL crc_err_pulse: got %b want 00", {ack0, err0}); end
        // readback through port 1: contents must be unchanged
        req1 = 1'b1; rnw1 = 1'b1; addr1 = 8'h10;
        step();
        req1 = 1'b0;
        step(); step();
        n_vec++; if (ack1 !== 1'b1 || rdata1 !== 16'hBEEF) begin n_miss++; $display("FAIL crc_readback: got ack1=%b rdata1=%h want 1/beef", ack1, rdata1); end
        n_vec++; if (err0 !== 1'b0) begin n_miss++; $display("FAIL crc_p1_err: got %b want 0", err0); end
        step();
    endtask

    task automatic test_drop_req();
        int n_ack;
        req1 = 1'b1; rnw1 = 1'b0; addr1 = 8'h40; wdata1 = 16'hA5A5;
        step();
        req1 = 1'b0;
        n_vec++; if (reg_req !== 1'b1) begin n_miss++; $display("FAIL drop_req: got %b want 1", reg_req); end
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ack1 === 1'b1) n_ack++;
        end
        n_vec++; if (n_ack != 1) begin n_miss++; $display("FAIL drop_ack_count: got %0d want 1", n_ack); end
        req0 = 1'b1; rnw0 = 1'b1; addr0 = 8'h40;
        step();
        req0 = 1'b0;
        step(); step();
        n_vec++; if (ack0 !== 1'b1 || rdata0 !== 16'hA5A5) begin n_miss++; $display("FAIL drop_readback: got ack0=%b rdata0=%h want 1/a5a5", ack0, rdata0); end
        step();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_addr;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; rnw0 = 1'b0; addr0 = 8'h30; wdata0 = 16'h0A0A; crc_ok0 = 1'b1;
        req1 = 1'b1; rnw1 = 1'b0; addr1 = 8'h31; wdata1 = 16'h0B0B;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 8'h30 : 8'h31;
            step();
            n_vec++; if (reg_req !== 1'b1 || reg_addr !== exp_addr) begin n_miss++; $display("FAIL rr_grant%0d: got req=%b addr=%h want 1/%h", k, reg_req, reg_addr, exp_addr); end
            step();
            n_vec++; if (ack0 !== (k % 2 == 0) || ack1 !== (k % 2 == 1)) begin n_miss++; $display("FAIL rr_ack%0d: got ack0=%b ack1=%b", k, ack0, ack1); end
            step();
            n_vec++; if (reg_req !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL rr_gap%0d: got req=%b busy=%b want 0/0", k, reg_req, busy); end
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        step();
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rr_quiet: got busy=%b want 0", busy); end
    endtask

    task automatic test_rdlat3();
        req0_b = 1'b1; rnw0_b = 1'b1; addr0_b = 8'h55;
        step();
        req0_b = 1'b0;
        n_vec++; if (reg_req_b !== 1'b1) begin n_miss++; $display("FAIL lat3_req: got %b want 1", reg_req_b); end
        step(); step(); step();
        n_vec++; if (ack0_b !== 1'b0 || busy_b !== 1'b1) begin n_miss++; $display("FAIL lat3_early: got ack0=%b busy=%b want 0/1", ack0_b, busy_b); end
        step();
        n_vec++; if (ack0_b !== 1'b1 || rdata0_b !== 16'h1234) begin n_miss++; $display("FAIL lat3_ack: got ack0=%b rdata0=%h want 1/1234", ack0_b, rdata0_b); end
        step();
    endtask

    task automatic test_reset_in_wait();
        int n_ack;
        req0_b = 1'b1; rnw0_b = 1'b1; addr0_b = 8'h66;
        step();
        req0_b = 1'b0;
        step();          // WAIT 1
        step();          // WAIT 2
        reset = 1'b1;
        step();
        n_vec++; if (fsm_state_b !== 2'd0 || busy_b !== 1'b0) begin n_miss++; $display("FAIL rw_state: got state=%0d busy=%b want 0/0", fsm_state_b, busy_b); end
        n_vec++; if ({ack0_b, err0_b, reg_req_b, reg_rnw_b} !== 4'b0000) begin n_miss++; $display("FAIL rw_flags: got %b want 0000", {ack0_b, err0_b, reg_req_b, reg_rnw_b}); end
        n_vec++; if (reg_addr_b !== 8'h00 || rdata0_b !== 16'h0000) begin n_miss++; $display("FAIL rw_data: got addr=%h rdata0=%h want 00/0000", reg_addr_b, rdata0_b); end
        reset = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack0_b === 1'b1) n_ack++;
        end
        n_vec++; if (n_ack != 0) begin n_miss++; $display("FAIL rw_noack: got %0d acks want 0", n_ack); end
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1;
        req0 = 1'b0; rnw0 = 1'b0; addr0 = 8'h00; wdata0 = 16'h0000; crc_ok0 = 1'b0;
        req1 = 1'b0; rnw1 = 1'b0; addr1 = 8'h00; wdata1 = 16'h0000;
        req0_b = 1'b0; rnw0_b = 1'b0; addr0_b = 8'h00;
        test_reset();
        test_p1_write();
        test_p0_read();
        test_p0_write_ok();
        test_crc_reject();
        test_drop_req();
        test_round_robin();
        test_rdlat3();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, register address width.
REQ-002 Parameter DATA_W, default 16, register data width.
REQ-003 Parameter RD_LAT, default 1, register-file read latency in cycles; legal range 1..3.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0 / rnw0 / addr0 / wdata0  input  1/1/ADDR_W/DATA_W  port 0 (I2C side) request, 1=read, address, write data.
REQ-007 crc_ok0  input  1  port 0 goodCRC qualifier for writes.
REQ-008 ack0 / rdata0 / err0  output  1/DATA_W/1  port 0 completion pulse, read data, write-rejected flag.
REQ-009 req1 / rnw1 / addr1 / wdata1  input  1/1/ADDR_W/DATA_W  port 1 (protocol engine) request signals.
REQ-010 ack1 / rdata1  output  1/DATA_W  port 1 completion pulse, read data.
REQ-011 reg_req / reg_rnw / reg_addr / reg_wdata  output  1/1/ADDR_W/DATA_W  shared register-file request bus.
REQ-012 reg_rdata  input  DATA_W  register-file read data.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; exactly one transaction in flight.
REQ-015 IDLE: sample req0/req1; none -> stay IDLE; else latch winner's rnw/addr/wdata and go ISSUE next cycle.
REQ-016 Arbitration SHALL be round-robin: both requesting -> grant port not granted last; single requester -> granted immediately.
REQ-017 Last-grant pointer SHALL update only on a grant; after reset port 0 wins first tie.
REQ-018 ISSUE: reg_req=1 for exactly one cycle with latched rnw/addr/wdata; reg_addr/reg_wdata/reg_rnw SHALL hold latched values through DONE.
REQ-019 Write (rnw=0): ISSUE -> DONE; ack in cycle T+1 where T is the reg_req cycle.
REQ-020 Read (rnw=1): ISSUE -> WAIT for RD_LAT cycles; reg_rdata sampled at end of cycle T+RD_LAT; ack in cycle T+RD_LAT+1.
REQ-021 DONE: ackN=1 for exactly one cycle on granted port; rdataN updated for reads only, same cycle as ack; DONE -> IDLE.
REQ-022 rdata0/rdata1 SHALL hold last value until next read ack on that port; writes SHALL NOT alter them.
REQ-023 Port 0 write with crc_ok0=0 at grant SHALL NOT assert reg_req; FSM goes ISSUE-cycle-suppressed -> DONE, ack0=1 and err0=1 same cycle.
REQ-024 err0 SHALL be a one-cycle pulse coincident with ack0; 0 at all other times; crc_ok0 ignored for reads and port 1.
REQ-025 Requests SHALL be sampled only in IDLE; minimum one IDLE cycle between transactions; back-to-back grant alternates ports.
REQ-026 Requester deasserting req after grant SHALL NOT abort; transaction completes and ack still pulses.
REQ-027 reqN still high in IDLE after its ack SHALL be treated as a new request.
REQ-028 Port 1 has no CRC gating; all its writes are issued.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, abandon any in-flight transaction, and clear next cycle: ack0, ack1, err0, reg_req, reg_rnw, busy=0; reg_addr, reg_wdata, rdata0, rdata1 = 0; pointer -> port 0 priority.
REQ-030 Reset during WAIT SHALL discard the pending read; no ack issued afterward for it.
REQ-031 While reset is high all outputs SHALL remain at reset values and requests SHALL be ignored.

Verification
REQ-032 Port 1 write addr=0x10 data=0xBEEF -> reg_req 1 cycle with 0x10/0xBEEF, ack1 next cycle, rdata1 unchanged.
REQ-033 Port 0 read addr=0x10, RD_LAT=1, reg_rdata=0xBEEF in T+1 -> ack0 and rdata0=0xBEEF in T+2, err0=0.
REQ-034 req0 and req1 asserted together, held, after reset -> grants order 0,1,0,1; one IDLE cycle between each ack and next reg_req.
REQ-035 Port 0 write with crc_ok0=0 -> no reg_req, ack0=1 and err0=1 same cycle; register contents unchanged on readback.
REQ-036 Read with RD_LAT=3, reset asserted in second WAIT cycle -> IDLE next cycle, no ack, all outputs at reset values.
REQ-037 req1 dropped in ISSUE cycle of a write -> write still performed and ack1 pulses once.
